// File: rtl/mc_pkg.sv
// Shared encodings for the multicycle sequencer: states, opcodes and datapath select codes.
package mc_pkg;

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StFetch  = 3'd1,
    StDecode = 3'd2,
    StExec   = 3'd3,
    StMem    = 3'd4,
    StWb     = 3'd5
  } state_e;

  localparam logic [2:0] OpR       = 3'b000;
  localparam logic [2:0] OpLw      = 3'b001;
  localparam logic [2:0] OpSw      = 3'b010;
  localparam logic [2:0] OpBeq     = 3'b011;
  localparam logic [2:0] OpJ       = 3'b100;
  localparam logic [2:0] OpAddi    = 3'b101;
  localparam logic [2:0] OpAndi    = 3'b110;
  localparam logic [2:0] OpIllegal = 3'b111;

  localparam logic [1:0] AluAdd   = 2'b00;
  localparam logic [1:0] AluSub   = 2'b01;
  localparam logic [1:0] AluFunct = 2'b10;
  localparam logic [1:0] AluAnd   = 2'b11;

  localparam logic [1:0] SrcBReg   = 2'b00;
  localparam logic [1:0] SrcBFour  = 2'b01;
  localparam logic [1:0] SrcBImm   = 2'b10;
  localparam logic [1:0] SrcBImmSh = 2'b11;

  localparam logic [1:0] PcAlu    = 2'b00;
  localparam logic [1:0] PcAluOut = 2'b01;
  localparam logic [1:0] PcJump   = 2'b10;

endpackage

// File: rtl/mc_output_decode.sv
// Combinational strobe decode for the multicycle sequencer: (state, opcode, mem_ready) -> datapath
// controls. Anything not driven for a state stays 0.
module mc_output_decode
  import mc_pkg::*;
(
  input  state_e     state_i,
  input  logic [2:0] op_i,
  input  logic       mem_ready_i,
  output logic       pc_write_o,
  output logic       pc_write_cond_o,
  output logic       ir_write_o,
  output logic       i_or_d_o,
  output logic       mem_read_o,
  output logic       mem_write_o,
  output logic       mem_to_reg_o,
  output logic       reg_dst_o,
  output logic       reg_write_o,
  output logic       alu_src_a_o,
  output logic [1:0] alu_src_b_o,
  output logic [1:0] alu_op_o,
  output logic [1:0] pc_source_o,
  output logic       illegal_op_o
);

  always_comb begin
    pc_write_o      = 1'b0;
    pc_write_cond_o = 1'b0;
    ir_write_o      = 1'b0;
    i_or_d_o        = 1'b0;
    mem_read_o      = 1'b0;
    mem_write_o     = 1'b0;
    mem_to_reg_o    = 1'b0;
    reg_dst_o       = 1'b0;
    reg_write_o     = 1'b0;
    alu_src_a_o     = 1'b0;
    alu_src_b_o     = SrcBReg;
    alu_op_o        = AluAdd;
    pc_source_o     = PcAlu;
    illegal_op_o    = 1'b0;

    case (state_i)
      StFetch: begin
        mem_read_o  = 1'b1;
        alu_src_b_o = SrcBFour;
        ir_write_o  = mem_ready_i;
        pc_write_o  = mem_ready_i;
      end
      StDecode: begin
        // ALU precomputes the branch target while the opcode is examined.
        alu_src_b_o = SrcBImmSh;
        if (op_i == OpJ) begin
          pc_write_o  = 1'b1;
          pc_source_o = PcJump;
        end
        illegal_op_o = (op_i == OpIllegal);
      end
      StExec: begin
        alu_src_a_o = 1'b1;
        case (op_i)
          OpR: begin
            alu_src_b_o = SrcBReg;
            alu_op_o    = AluFunct;
          end
          OpAndi: begin
            alu_src_b_o = SrcBImm;
            alu_op_o    = AluAnd;
          end
          OpBeq: begin
            alu_src_b_o     = SrcBReg;
            alu_op_o        = AluSub;
            pc_write_cond_o = 1'b1;
            pc_source_o     = PcAluOut;
          end
          default: begin
            alu_src_b_o = SrcBImm;
            alu_op_o    = AluAdd;
          end
        endcase
      end
      StMem: begin
        i_or_d_o    = 1'b1;
        mem_read_o  = (op_i == OpLw);
        mem_write_o = (op_i == OpSw);
      end
      StWb: begin
        reg_write_o  = 1'b1;
        reg_dst_o    = (op_i == OpR);
        mem_to_reg_o = (op_i == OpLw);
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle instruction sequencer: FETCH/DECODE/EXEC/MEM/WB walk with memory-ready stalls and a
// retired-instruction counter.
module multicycle_control
  import mc_pkg::*;
#(
  parameter int unsigned COUNT_W = 16
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               run,
  input  logic [2:0]         opcode,
  input  logic               mem_ready,
  output logic               pc_write,
  output logic               pc_write_cond,
  output logic               ir_write,
  output logic               i_or_d,
  output logic               mem_read,
  output logic               mem_write,
  output logic               mem_to_reg,
  output logic               reg_dst,
  output logic               reg_write,
  output logic               alu_src_a,
  output logic [1:0]         alu_src_b,
  output logic [1:0]         alu_op,
  output logic [1:0]         pc_source,
  output logic               illegal_op,
  output logic [2:0]         state,
  output logic [COUNT_W-1:0] instr_count
);

  state_e             state_q, state_d, fetch_or_idle;
  logic [2:0]         op_q, op_d, dec_op;
  logic [COUNT_W-1:0] count_q, count_d;
  logic               retire;

  // op_q only becomes valid after DECODE, so DECODE itself looks at the live opcode.
  assign dec_op        = (state_q == StDecode) ? opcode : op_q;
  assign fetch_or_idle = run ? StFetch : StIdle;

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    retire  = 1'b0;
    case (state_q)
      StIdle:  if (run) state_d = StFetch;
      StFetch: if (mem_ready) state_d = StDecode;
      StDecode: begin
        op_d = opcode;
        if (opcode == OpJ) begin
          retire  = 1'b1;
          state_d = fetch_or_idle;
        end else if (opcode == OpIllegal) begin
          state_d = StIdle;
        end else begin
          state_d = StExec;
        end
      end
      StExec: begin
        case (op_q)
          OpR, OpAddi, OpAndi: state_d = StWb;
          OpLw, OpSw:          state_d = StMem;
          OpBeq: begin
            retire  = 1'b1;
            state_d = fetch_or_idle;
          end
          default:             state_d = StIdle;
        endcase
      end
      StMem: begin
        if (mem_ready) begin
          if (op_q == OpSw) begin
            retire  = 1'b1;
            state_d = fetch_or_idle;
          end else begin
            state_d = StWb;
          end
        end
      end
      StWb: begin
        retire  = 1'b1;
        state_d = fetch_or_idle;
      end
      default: state_d = StIdle;
    endcase
  end

  assign count_d = retire ? count_q + COUNT_W'(1) : count_q;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= StIdle;
      op_q    <= OpR;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      count_q <= count_d;
    end
  end

  assign state       = state_q;
  assign instr_count = count_q;

  mc_output_decode u_decode (
    .state_i         (state_q),
    .op_i            (dec_op),
    .mem_ready_i     (mem_ready),
    .pc_write_o      (pc_write),
    .pc_write_cond_o (pc_write_cond),
    .ir_write_o      (ir_write),
    .i_or_d_o        (i_or_d),
    .mem_read_o      (mem_read),
    .mem_write_o     (mem_write),
    .mem_to_reg_o    (mem_to_reg),
    .reg_dst_o       (reg_dst),
    .reg_write_o     (reg_write),
    .alu_src_a_o     (alu_src_a),
    .alu_src_b_o     (alu_src_b),
    .alu_op_o        (alu_op),
    .pc_source_o     (pc_source),
    .illegal_op_o    (illegal_op)
  );

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: a per-cycle vector table plus reset and counter-wrap runs.
module tb_multicycle_control;

  logic       clk;
  logic       reset_n;
  logic       run;
  logic [2:0] opcode;
  logic       mem_ready;

  logic        pw, pwc, irw, iod, mrd, mwr, m2r, rdst, rw, asa, ill;
  logic [1:0]  asb, aop, psrc;
  logic [2:0]  st;
  logic [15:0] cnt;

  logic        pw4, pwc4, irw4, iod4, mrd4, mwr4, m2r4, rdst4, rw4, asa4, ill4;
  logic [1:0]  asb4, aop4, psrc4;
  logic [2:0]  st4;
  logic [3:0]  cnt4;

  logic [16:0] strb, strb4;
  assign strb  = {pw, pwc, irw, iod, mrd, mwr, m2r, rdst, rw, asa, asb, aop, psrc, ill};
  assign strb4 = {pw4, pwc4, irw4, iod4, mrd4, mwr4, m2r4, rdst4, rw4, asa4, asb4, aop4, psrc4,
                  ill4};

  multicycle_control dut (
    .clk(clk), .reset_n(reset_n), .run(run), .opcode(opcode), .mem_ready(mem_ready),
    .pc_write(pw), .pc_write_cond(pwc), .ir_write(irw), .i_or_d(iod), .mem_read(mrd),
    .mem_write(mwr), .mem_to_reg(m2r), .reg_dst(rdst), .reg_write(rw), .alu_src_a(asa),
    .alu_src_b(asb), .alu_op(aop), .pc_source(psrc), .illegal_op(ill), .state(st),
    .instr_count(cnt)
  );

  multicycle_control #(.COUNT_W(4)) dut4 (
    .clk(clk), .reset_n(reset_n), .run(run), .opcode(opcode), .mem_ready(mem_ready),
    .pc_write(pw4), .pc_write_cond(pwc4), .ir_write(irw4), .i_or_d(iod4), .mem_read(mrd4),
    .mem_write(mwr4), .mem_to_reg(m2r4), .reg_dst(rdst4), .reg_write(rw4), .alu_src_a(asa4),
    .alu_src_b(asb4), .alu_op(aop4), .pc_source(psrc4), .illegal_op(ill4), .state(st4),
    .instr_count(cnt4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        run;
    logic [2:0]  op;
    logic        rdy;
    logic [2:0]  st;
    logic [16:0] strb;
    logic [15:0] cnt;
  } vec_t;

  vec_t vq[$];

  function automatic logic [16:0] pk(input logic p_w, p_wc, i_rw, i_od, m_rd, m_wr, m_2r, r_dst,
                                     r_w, a_sa, input logic [1:0] a_sb, a_op, p_src,
                                     input logic i_ll);
    return {p_w, p_wc, i_rw, i_od, m_rd, m_wr, m_2r, r_dst, r_w, a_sa, a_sb, a_op, p_src, i_ll};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic add(input logic r, input logic [2:0] o, input logic m, input logic [2:0] s,
                     input logic [16:0] sb, input logic [15:0] c);
    vq.push_back('{r, o, m, s, sb, c});
  endtask

  task automatic drive(input logic r, input logic [2:0] o, input logic m);
    run = r; opcode = o; mem_ready = m;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [16:0] s_0, s_fw, s_fr, s_dec, s_dj, s_dill, s_er, s_ei, s_eand, s_ebeq;
  logic [16:0] s_mlw, s_msw, s_wr, s_wlw, s_wi;

  initial begin
    s_0    = '0;
    s_fw   = pk(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 2'b01, 2'b00, 2'b00, 0);
    s_fr   = pk(1, 0, 1, 0, 1, 0, 0, 0, 0, 0, 2'b01, 2'b00, 2'b00, 0);
    s_dec  = pk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b11, 2'b00, 2'b00, 0);
    s_dj   = pk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b11, 2'b00, 2'b10, 0);
    s_dill = pk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b11, 2'b00, 2'b00, 1);
    s_er   = pk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b10, 2'b00, 0);
    s_ei   = pk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b10, 2'b00, 2'b00, 0);
    s_eand = pk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b10, 2'b11, 2'b00, 0);
    s_ebeq = pk(0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b01, 2'b01, 0);
    s_mlw  = pk(0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 0);
    s_msw  = pk(0, 0, 0, 1, 0, 1, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 0);
    s_wr   = pk(0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 2'b00, 2'b00, 2'b00, 0);
    s_wlw  = pk(0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 2'b00, 2'b00, 2'b00, 0);
    s_wi   = pk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 2'b00, 2'b00, 2'b00, 0);

    //   run op     rdy  state  strobes  count
    add(1, 3'd0, 0, 3'd0, s_0,    16'd0);  // reset state, IDLE
    add(1, 3'd0, 1, 3'd1, s_fr,   16'd0);  // R-type
    add(1, 3'd0, 1, 3'd2, s_dec,  16'd0);
    add(1, 3'd3, 1, 3'd3, s_er,   16'd0);  // opcode changed after DECODE is ignored
    add(1, 3'd7, 1, 3'd5, s_wr,   16'd0);
    add(1, 3'd0, 0, 3'd1, s_fw,   16'd1);  // LW, 3 fetch waits
    add(1, 3'd0, 0, 3'd1, s_fw,   16'd1);
    add(1, 3'd0, 0, 3'd1, s_fw,   16'd1);
    add(1, 3'd0, 1, 3'd1, s_fr,   16'd1);
    add(1, 3'd1, 1, 3'd2, s_dec,  16'd1);
    add(1, 3'd5, 1, 3'd3, s_ei,   16'd1);
    add(1, 3'd0, 0, 3'd4, s_mlw,  16'd1);  // 2 mem waits
    add(1, 3'd0, 0, 3'd4, s_mlw,  16'd1);
    add(1, 3'd0, 1, 3'd4, s_mlw,  16'd1);
    add(1, 3'd0, 1, 3'd5, s_wlw,  16'd1);
    add(1, 3'd0, 1, 3'd1, s_fr,   16'd2);  // BEQ
    add(1, 3'd3, 1, 3'd2, s_dec,  16'd2);
    add(1, 3'd4, 1, 3'd3, s_ebeq, 16'd2);
    add(1, 3'd0, 1, 3'd1, s_fr,   16'd3);  // J
    add(1, 3'd4, 1, 3'd2, s_dj,   16'd3);
    add(1, 3'd0, 1, 3'd1, s_fr,   16'd4);  // illegal
    add(1, 3'd7, 1, 3'd2, s_dill, 16'd4);
    add(1, 3'd0, 1, 3'd0, s_0,    16'd4);
    add(1, 3'd0, 1, 3'd1, s_fr,   16'd4);  // ANDI
    add(1, 3'd6, 1, 3'd2, s_dec,  16'd4);
    add(1, 3'd0, 1, 3'd3, s_eand, 16'd4);
    add(1, 3'd0, 1, 3'd5, s_wi,   16'd4);
    add(1, 3'd0, 1, 3'd1, s_fr,   16'd5);  // SW, 1 mem wait
    add(1, 3'd2, 1, 3'd2, s_dec,  16'd5);
    add(1, 3'd0, 1, 3'd3, s_ei,   16'd5);
    add(1, 3'd0, 0, 3'd4, s_msw,  16'd5);
    add(1, 3'd0, 1, 3'd4, s_msw,  16'd5);
    add(1, 3'd0, 1, 3'd1, s_fr,   16'd6);  // ADDI, run dropped mid-instruction
    add(0, 3'd5, 1, 3'd2, s_dec,  16'd6);
    add(0, 3'd0, 1, 3'd3, s_ei,   16'd6);
    add(0, 3'd0, 1, 3'd5, s_wi,   16'd6);
    add(0, 3'd0, 1, 3'd0, s_0,    16'd7);
    add(0, 3'd0, 1, 3'd0, s_0,    16'd7);

    reset_n = 1'b0;
    run = 1'b0; opcode = 3'd0; mem_ready = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;

    for (int i = 0; i < vq.size(); i++) begin
      drive(vq[i].run, vq[i].op, vq[i].rdy);
      chk($sformatf("vec%0d state", i), 32'(st), 32'(vq[i].st));
      chk($sformatf("vec%0d strobes", i), 32'(strb), 32'(vq[i].strb));
      chk($sformatf("vec%0d count", i), 32'(cnt), 32'(vq[i].cnt));
      chk($sformatf("vec%0d state4", i), 32'(st4), 32'(vq[i].st));
      chk($sformatf("vec%0d strobes4", i), 32'(strb4), 32'(vq[i].strb));
      chk($sformatf("vec%0d count4", i), 32'(cnt4), 32'(vq[i].cnt[3:0]));
      tick();
    end

    // Reset in the middle of an SW memory access.
    drive(1, 3'd0, 0); tick();
    drive(1, 3'd0, 1); tick();
    drive(1, 3'd2, 1); tick();
    drive(1, 3'd0, 0); tick();
    drive(1, 3'd0, 0);
    chk("sw mem state", 32'(st), 32'd4);
    chk("sw mem_write", 32'(mwr), 32'd1);
    reset_n = 1'b0;
    tick();
    chk("rst1 state", 32'(st), 32'd0);
    chk("rst1 mem_write", 32'(mwr), 32'd0);
    chk("rst1 i_or_d", 32'(iod), 32'd0);
    chk("rst1 count", 32'(cnt), 32'd0);
    chk("rst1 count4", 32'(cnt4), 32'd0);
    tick();
    chk("rst2 state", 32'(st), 32'd0);
    chk("rst2 strobes", 32'(strb), 32'd0);
    reset_n = 1'b1;

    // 16 back-to-back ADDIs wrap the 4-bit counter.
    drive(1, 3'd0, 1); tick();
    for (int k = 0; k < 16; k++) begin
      drive(1, 3'd0, 1); tick();
      drive(1, 3'd5, 1); tick();
      drive(1, 3'd0, 1); tick();
      drive(1, 3'd0, 1);
      if (k == 15) begin
        chk("wrap pre count4", 32'(cnt4), 32'd15);
        chk("wrap pre count", 32'(cnt), 32'd15);
      end
      tick();
    end
    drive(1, 3'd0, 1);
    chk("wrap count4", 32'(cnt4), 32'd0);
    chk("wrap count", 32'(cnt), 32'd16);
    chk("wrap state", 32'(st), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
